load_store_unit: RTL

Memory-stage block directly downstream of the integer ALU. It takes the ALU result as the effective address, plus the store data (integer rs2 or FP register for FLW/FSW), and runs one load or store at a time over a simple request/grant/rvalid word bus. It formats byte enables and store data, and extracts and sign/zero-extends load data. While busy it stalls the pipeline, and it reports misaligned or illegal accesses without touching the bus.

---
 rtl/load_store_unit.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: runs one access at a time over a req/gnt/rvalid word bus.
// It formats byte enables and store data, and sign/zero-extends load data.
module load_store_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    output logic         stall,
    input  logic         mem_write,
    input  logic [2:0]   funct3,
    input  logic [N-1:0] addr,
    input  logic [N-1:0] wdata,
    output logic         rsp_valid,
    output logic [N-1:0] rdata,
    output logic         fault,
    output logic         bus_req,
    output logic         bus_we,
    output logic [N-1:0] bus_addr,
    output logic [N-1:0] bus_wdata,
    output logic [3:0]   bus_be,
    input  logic         bus_gnt,
    input  logic         bus_rvalid,
    input  logic [N-1:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_t         state_q, state_d;
    logic           we_q, we_d;
    logic [2:0]     funct3_q, funct3_d;
    logic [1:0]     off_q, off_d;
    logic [3:0]     be_q, be_d;
    logic [N-1:0]   bus_addr_q, bus_addr_d;
    logic [N-1:0]   bus_wdata_q, bus_wdata_d;
    logic [N-1:0]   rdata_q, rdata_d;
    logic           fault_q, fault_d;

    logic           accept;
    logic           acc_fault;
    logic [3:0]     st_be;
    logic [N-1:0]   st_wdata;
    logic [N-1:0]   ld_shifted;
    logic [N-1:0]   ld_data;

    assign accept = req_valid && (state_q == IDLE);

    // Fault decode works on the live inputs; it only matters on the accept edge.
    always_comb begin
        acc_fault = 1'b0;
        case (funct3)
            F3_B, F3_BU: acc_fault = 1'b0;
            F3_H, F3_HU: acc_fault = addr[0];
            F3_W:        acc_fault = (addr[1:0] != 2'b00);
            default:     acc_fault = 1'b1;
        endcase
        if (mem_write && funct3[2]) begin
            acc_fault = 1'b1;
        end
    end

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = wdata;
        case (funct3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << addr[1:0];
                st_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << addr[1:0];
                st_wdata = {2{wdata[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = wdata;
            end
        endcase
    end

    always_comb begin
        ld_shifted = bus_rdata >> {off_q, 3'b000};
        case (funct3_q)
            F3_B:    ld_data = {{(N-8){ld_shifted[7]}}, ld_shifted[7:0]};
            F3_BU:   ld_data = {{(N-8){1'b0}}, ld_shifted[7:0]};
            F3_H:    ld_data = {{(N-16){ld_shifted[15]}}, ld_shifted[15:0]};
            F3_HU:   ld_data = {{(N-16){1'b0}}, ld_shifted[15:0]};
            default: ld_data = ld_shifted;
        endcase
    end

    always_comb begin
        // NOTE: every *_d gets its hold value first, so no path through the case infers a latch.
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        be_d        = be_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
        fault_d     = fault_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d     = mem_write;
                    funct3_d = funct3;
                    off_d    = addr[1:0];
                    if (acc_fault) begin
                        fault_d = 1'b1;
                        rdata_d = '0;
                        state_d = RESP;
                    end else begin
                        bus_addr_d = {addr[N-1:2], 2'b00};
                        be_d       = mem_write ? st_be : 4'b0000;
                        if (mem_write) begin
                            bus_wdata_d = st_wdata;
                        end
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (bus_gnt) begin
                    if (we_q) begin
                        fault_d = 1'b0;
                        rdata_d = '0;
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus_rvalid) begin
                    fault_d = 1'b0;
                    rdata_d = ld_data;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments; the combinational block above uses blocking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            be_q        <= 4'b0000;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            rdata_q     <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            be_q        <= be_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
            fault_q     <= fault_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign stall     = req_valid && !req_ready;
    assign rsp_valid = (state_q == RESP);
    assign rdata     = rdata_q;
    assign fault     = fault_q;
    assign bus_req   = (state_q == REQ);
    assign bus_we    = (state_q == REQ) && we_q;
    assign bus_be    = (state_q == REQ) ? be_q : 4'b0000;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;

endmodule
